// File: rtl/pad_cmd_pkg.sv
// Shared definitions for pad_cmd_gen: command codes, DAS FSM states,
// pending-bit indices and the priority arbiter helpers.
package pad_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_LEFT    = 3'd1,
        CMD_RIGHT   = 3'd2,
        CMD_DOWN    = 3'd3,
        CMD_START   = 3'd4,
        CMD_RESTART = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } das_state_e;

    // Bit index order doubles as priority order: a higher index wins.
    localparam int PEND_RIGHT   = 0;
    localparam int PEND_LEFT    = 1;
    localparam int PEND_DOWN    = 2;
    localparam int PEND_START   = 3;
    localparam int PEND_RESTART = 4;
    localparam int PEND_N       = 5;

    localparam logic [PEND_N-1:0] PEND_MOVE_MASK = 5'b00111;

    function automatic logic [PEND_N-1:0] pick_pend(input logic [PEND_N-1:0] p);
        pick_pend = '0;
        for (int i = 0; i < PEND_N; i++) begin
            if (p[i]) begin
                pick_pend    = '0;
                pick_pend[i] = 1'b1;
            end
        end
    endfunction

    function automatic cmd_e onehot_to_cmd(input logic [PEND_N-1:0] oh);
        case (oh)
            5'b10000: onehot_to_cmd = CMD_RESTART;
            5'b01000: onehot_to_cmd = CMD_START;
            5'b00100: onehot_to_cmd = CMD_DOWN;
            5'b00010: onehot_to_cmd = CMD_LEFT;
            5'b00001: onehot_to_cmd = CMD_RIGHT;
            default:  onehot_to_cmd = CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pad_cmd_gen_autorepeat.sv
// pad_autorepeat: per-key rising-edge detect plus delayed auto-shift FSM
// counting ms ticks; emits a one-cycle event per press / repeat.
module pad_autorepeat
    import pad_cmd_pkg::*;
#(
    parameter int DAS_DELAY_MS = 200,
    parameter int DAS_RATE_MS  = 50
) (
    input  logic pclk,
    input  logic rst,
    input  logic i_level,
    input  logic i_ms_tick,
    input  logic i_hold,
    output logic o_event
);

    localparam int MS_MAX = (DAS_DELAY_MS > DAS_RATE_MS) ? DAS_DELAY_MS : DAS_RATE_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);

    logic             r_lvl;
    logic             r_lvl_prev;
    das_state_e       r_state;
    das_state_e       w_state_nxt;
    logic [MS_W-1:0]  r_ms_cnt;
    logic [MS_W-1:0]  w_ms_cnt_nxt;
    logic             w_rise;

    assign w_rise = r_lvl & ~r_lvl_prev;

    // Level history runs regardless of i_hold so a key held through a pause
    // shows no rising edge once the hold is released.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_lvl      <= 1'b0;
            r_lvl_prev <= 1'b0;
            r_state    <= IDLE;
            r_ms_cnt   <= '0;
        end else begin
            r_lvl      <= i_level;
            r_lvl_prev <= r_lvl;
            r_state    <= w_state_nxt;
            r_ms_cnt   <= w_ms_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ms_cnt_nxt = r_ms_cnt;
        o_event      = 1'b0;
        if (i_hold || !r_lvl) begin
            w_state_nxt  = IDLE;
            w_ms_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_state_nxt  = DELAY;
                        w_ms_cnt_nxt = '0;
                        o_event      = 1'b1;
                    end
                end
                DELAY: begin
                    if (i_ms_tick) begin
                        if (r_ms_cnt == MS_W'(DAS_DELAY_MS - 1)) begin
                            w_state_nxt  = REPEAT;
                            w_ms_cnt_nxt = '0;
                            o_event      = 1'b1;
                        end else begin
                            w_ms_cnt_nxt = r_ms_cnt + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (i_ms_tick) begin
                        if (r_ms_cnt == MS_W'(DAS_RATE_MS - 1)) begin
                            w_ms_cnt_nxt = '0;
                            o_event      = 1'b1;
                        end else begin
                            w_ms_cnt_nxt = r_ms_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_ms_cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pad_cmd_gen.sv
// pad_cmd_gen: turns debounced pad/button inputs into prioritised game commands
// with DAS auto-repeat and pause tracking. PAD_DROP_CNT_EN adds drop_cnt.
module pad_cmd_gen
    import pad_cmd_pkg::*;
#(
    parameter int PRESC        = 65000,
    parameter int DAS_DELAY_MS = 200,
    parameter int DAS_RATE_MS  = 50
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       pad_Sd,
    input  logic       bttn_Dd,
    input  logic       pad_Rl,
    input  logic       pad_Ll,
    input  logic       pad_Dl,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
`ifdef PAD_DROP_CNT_EN
    output logic [7:0] drop_cnt,
`endif
    output logic       paused
);

    localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PRESC_W-1:0] r_presc;
    logic               w_ms_tick;
    logic               w_evt_r, w_evt_l, w_evt_d;
    logic [PEND_N-1:0]  w_evt;
    logic [PEND_N-1:0]  r_pend;
    logic [PEND_N-1:0]  w_pick;
    logic [PEND_N-1:0]  w_clr;
    logic [PEND_N-1:0]  w_pend_keep;
    logic               r_valid;
    logic [2:0]         r_code;
    logic               r_paused;
    logic               w_acc;
    logic               w_load;
    logic               w_acc_start;
    logic               w_acc_restart;

    assign w_ms_tick = (r_presc == PRESC_W'(PRESC - 1));

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst)           r_presc <= '0;
        else if (w_ms_tick) r_presc <= '0;
        else                r_presc <= r_presc + 1'b1;
    end

    pad_autorepeat #(.DAS_DELAY_MS(DAS_DELAY_MS), .DAS_RATE_MS(DAS_RATE_MS)) u_das_r (
        .pclk(pclk), .rst(rst), .i_level(pad_Rl), .i_ms_tick(w_ms_tick),
        .i_hold(r_paused), .o_event(w_evt_r)
    );
    pad_autorepeat #(.DAS_DELAY_MS(DAS_DELAY_MS), .DAS_RATE_MS(DAS_RATE_MS)) u_das_l (
        .pclk(pclk), .rst(rst), .i_level(pad_Ll), .i_ms_tick(w_ms_tick),
        .i_hold(r_paused), .o_event(w_evt_l)
    );
    pad_autorepeat #(.DAS_DELAY_MS(DAS_DELAY_MS), .DAS_RATE_MS(DAS_RATE_MS)) u_das_d (
        .pclk(pclk), .rst(rst), .i_level(pad_Dl), .i_ms_tick(w_ms_tick),
        .i_hold(r_paused), .o_event(w_evt_d)
    );

    // Valid/ready: a command transfers on any edge where cmd_valid & cmd_ready;
    // while cmd_valid & !cmd_ready the slot holds code and valid unchanged.
    assign w_acc         = r_valid & cmd_ready;
    assign w_load        = ~r_valid | cmd_ready;
    assign w_acc_start   = w_acc && (r_code == CMD_START);
    assign w_acc_restart = w_acc && (r_code == CMD_RESTART);
    assign w_pick        = pick_pend(r_pend);

    always_comb begin
        w_evt                = '0;
        w_evt[PEND_RESTART]  = bttn_Dd;
        w_evt[PEND_START]    = pad_Sd;
        w_evt[PEND_DOWN]     = w_evt_d & ~r_paused;
        w_evt[PEND_LEFT]     = w_evt_l & ~r_paused;
        w_evt[PEND_RIGHT]    = w_evt_r & ~r_paused;
        w_clr                = w_load ? w_pick : '0;
        w_pend_keep          = r_pend & ~w_clr;
        if (r_paused || w_acc_restart) begin
            w_pend_keep = w_pend_keep & ~PEND_MOVE_MASK;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_pend   <= '0;
            r_valid  <= 1'b0;
            r_code   <= CMD_NONE;
            r_paused <= 1'b0;
        end else begin
            r_pend <= w_pend_keep | w_evt;
            if (w_load) begin
                r_valid <= |r_pend;
                r_code  <= onehot_to_cmd(w_pick);
            end
            if (w_acc_restart)    r_paused <= 1'b0;
            else if (w_acc_start) r_paused <= ~r_paused;
        end
    end

`ifdef PAD_DROP_CNT_EN
    logic [PEND_N-1:0] w_drop;
    logic [2:0]        w_drop_n;
    logic [8:0]        w_drop_sum;
    logic [7:0]        r_drop_cnt;

    // An event is lost when its bit is already set and survives this edge.
    always_comb begin
        w_drop   = w_evt & w_pend_keep;
        w_drop_n = '0;
        for (int i = 0; i < PEND_N; i++) begin
            w_drop_n = w_drop_n + {2'b00, w_drop[i]};
        end
        w_drop_sum = {1'b0, r_drop_cnt} + {6'd0, w_drop_n};
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst)                r_drop_cnt <= '0;
        else if (w_acc_restart)  r_drop_cnt <= '0;
        else if (w_drop_sum[8])  r_drop_cnt <= 8'hFF;
        else                     r_drop_cnt <= w_drop_sum[7:0];
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign cmd_valid = r_valid;
    assign cmd_code  = r_code;
    assign paused    = r_paused;

endmodule

// File: tb/tb_pad_cmd_gen.sv
// Directed bench for pad_cmd_gen with PRESC=4, DAS_DELAY_MS=3, DAS_RATE_MS=2.
// cyc counts rising edges since reset release; timebase ticks land on edges where cyc % 4 == 0.
module tb_pad_cmd_gen;
  import pad_cmd_pkg::*;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       pad_Sd = 1'b0;
  logic       bttn_Dd = 1'b0;
  logic       pad_Rl = 1'b0;
  logic       pad_Ll = 1'b0;
  logic       pad_Dl = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       paused;
`ifdef PAD_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int cnt;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 pclk = ~pclk;

  pad_cmd_gen #(.PRESC(4), .DAS_DELAY_MS(3), .DAS_RATE_MS(2)) dut (
    .pclk(pclk),
    .rst(rst),
    .pad_Sd(pad_Sd),
    .bttn_Dd(bttn_Dd),
    .pad_Rl(pad_Rl),
    .pad_Ll(pad_Ll),
    .pad_Dl(pad_Dl),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
`ifdef PAD_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .paused(paused)
  );

  // driver tasks
  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    pad_Sd = 1'b1;
    step();
    pad_Sd = 1'b0;
  endtask

  task automatic count_valid(input int n, output int c);
    c = 0;
    repeat (n) begin
      step();
      if (cmd_valid) c++;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_valid", 16'(cmd_valid), 16'd0);
    chk("rst_code", 16'(cmd_code), 16'(CMD_NONE));
    chk("rst_paused", 16'(paused), 16'd0);
    rst = 1'b1;
    cyc = 0;

    // single Left press: sampled at edge 1, valid after edge 3, exactly once
    pad_Ll = 1'b1;
    step();
    step();
    chk("left_not_early", 16'(cmd_valid), 16'd0);
    step();
    chk("left_valid", 16'(cmd_valid), 16'd1);
    chk("left_code", 16'(cmd_code), 16'(CMD_LEFT));
    pad_Ll = 1'b0;
    step();
    chk("left_accepted", 16'(cmd_valid), 16'd0);
    count_valid(20, cnt);
    chk("left_once", 16'(cnt), 16'd0);

    // Right held 30 cycles from cyc 26: valid at 29, then +12, then every 8
    exp_q = {16'd29, 16'd41, 16'd49, 16'd57};
    while (cyc < 80) begin
      if (cyc == 26) pad_Rl = 1'b1;
      if (cyc == 56) pad_Rl = 1'b0;
      step();
      if (cmd_valid) begin
        chk("rpt_code", 16'(cmd_code), 16'(CMD_RIGHT));
        if (exp_q.size() > 0) chk("rpt_cycle", 16'(cyc), exp_q.pop_front());
        else chk("rpt_extra", 16'(cyc), 16'd0);
      end
    end
    chk("rpt_count", 16'(exp_q.size()), 16'd0);

    // simultaneous Start/Restart/Down under stall: RESTART first and stable,
    // then START; accepting RESTART discards the pending DOWN
    cmd_ready = 1'b0;
    pad_Sd = 1'b1;
    bttn_Dd = 1'b1;
    pad_Dl = 1'b1;
    step();
    pad_Sd = 1'b0;
    bttn_Dd = 1'b0;
    chk("prio_not_early", 16'(cmd_valid), 16'd0);
    repeat (5) begin
      step();
      chk("stall_valid", 16'(cmd_valid), 16'd1);
      chk("stall_code", 16'(cmd_code), 16'(CMD_RESTART));
    end
    cmd_ready = 1'b1;
    step();
    chk("prio_start", 16'(cmd_code), 16'(CMD_START));
    chk("restart_unpaused", 16'(paused), 16'd0);
    step();
    chk("down_discarded", 16'(cmd_valid), 16'd0);
    chk("start_pauses", 16'(paused), 16'd1);
    pad_Dl = 1'b0;

    // paused: Left pulses suppressed
    pad_Ll = 1'b1;
    step();
    step();
    step();
    pad_Ll = 1'b0;
    count_valid(9, cnt);
    chk("paused_no_move", 16'(cnt), 16'd0);

    // Left held across unpause does not fire; a fresh press does
    pad_Ll = 1'b1;
    step();
    step();
    pulse_start();
    step();
    chk("unpause_cmd", 16'(cmd_code), 16'(CMD_START));
    chk("still_paused", 16'(paused), 16'd1);
    step();
    chk("unpaused", 16'(paused), 16'd0);
    count_valid(20, cnt);
    chk("held_no_fire", 16'(cnt), 16'd0);
    pad_Ll = 1'b0;
    step();
    step();
    pad_Ll = 1'b1;
    step();
    step();
    chk("repress_wait", 16'(cmd_valid), 16'd0);
    step();
    chk("repress_left", 16'(cmd_code), 16'(CMD_LEFT));
    pad_Ll = 1'b0;
    step();
    chk("repress_done", 16'(cmd_valid), 16'd0);

    // coalescing: three Start ticks under stall -> one in slot, one pending
    cmd_ready = 1'b0;
    pulse_start();
    step();
    chk("coal_slot", 16'(cmd_code), 16'(CMD_START));
    pulse_start();
    step();
    pulse_start();
    step();
    step();
    chk("coal_hold", 16'(cmd_code), 16'(CMD_START));
`ifdef PAD_DROP_CNT_EN
    chk("drop_cnt", 16'(drop_cnt), 16'd1);
`endif
    cmd_ready = 1'b1;
    step();
    chk("coal_second", 16'(cmd_code), 16'(CMD_START));
    chk("coal_paused", 16'(paused), 16'd1);
    step();
    chk("coal_empty", 16'(cmd_valid), 16'd0);
    chk("coal_unpaused", 16'(paused), 16'd0);

    // movement priority: DOWN > LEFT > RIGHT from the same edge
    cmd_ready = 1'b0;
    pad_Rl = 1'b1;
    pad_Ll = 1'b1;
    pad_Dl = 1'b1;
    step();
    step();
    pad_Rl = 1'b0;
    pad_Ll = 1'b0;
    pad_Dl = 1'b0;
    step();
    exp_q = {16'(CMD_DOWN), 16'(CMD_LEFT), 16'(CMD_RIGHT)};
    while (exp_q.size() > 0) begin
      chk("move_valid", 16'(cmd_valid), 16'd1);
      chk("move_order", 16'(cmd_code), exp_q.pop_front());
      cmd_ready = 1'b1;
      step();
    end
    chk("move_done", 16'(cmd_valid), 16'd0);

    // reset mid-handshake while paused
    pulse_start();
    step();
    step();
    chk("pre_rst_paused", 16'(paused), 16'd1);
    cmd_ready = 1'b0;
    pulse_start();
    step();
    chk("pre_rst_valid", 16'(cmd_valid), 16'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", 16'(cmd_valid), 16'd0);
    chk("rst_async_paused", 16'(paused), 16'd0);
    chk("rst_async_code", 16'(cmd_code), 16'(CMD_NONE));
    step();
    rst = 1'b1;
    cmd_ready = 1'b1;
    count_valid(10, cnt);
    chk("post_rst_quiet", 16'(cnt), 16'd0);
    pulse_start();
    step();
    chk("post_rst_cmd", 16'(cmd_code), 16'(CMD_START));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
